// File: rtl/chanlink_frame_rx.sv
// chanlink_frame_rx: 100-word channel-link frame checker and decoder.
// Define CHANLINK_RX_ERRCNT_EN to add the saturating ERR_CNT output.
module chanlink_frame_rx #(
  parameter int NDATA   = 96,
  parameter int GAP_MAX = 15
) (
  input  logic        WCLK,
  input  logic        RST_RESYNC,
  input  logic [15:0] DIN,
  input  logic        DVALID,
  input  logic        LAST_WRD,
  output logic [11:0] SMP_DATA,
  output logic        SMP_OVLP,
  output logic [6:0]  SMP_IDX,
  output logic        SMP_WE,
  output logic        FRM_DONE,
  output logic        CRC_ERR,
  output logic        FMT_ERR,
  output logic        TRUNC_ERR,
  output logic [5:0]  L1A_NUM,
  output logic [4:0]  L1A_BUF,
  output logic        WARN_OUT,
  output logic        L1A_PHS,
  output logic        SAMP16,
  output logic [15:0] FRM_CNT
`ifdef CHANLINK_RX_ERRCNT_EN
  ,
  output logic [15:0] ERR_CNT
`endif
);

  localparam int GW = $clog2(GAP_MAX + 1);
  localparam logic [6:0] PHS_LO = 7'd72;
  localparam logic [6:0] PHS_HI = 7'd77;
  localparam logic [6:0] S16_LO = 7'd90;
  localparam logic [6:0] S16_HI = 7'd95;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_CRC, S_TRL1, S_TRL2, S_TRL3
  } state_t;

  state_t          r_state, w_nstate;
  logic [6:0]      r_cnt;
  logic [14:0]     r_crc;
  logic [GW-1:0]   r_gap;
  logic            r_fmt, r_crce, r_phs, r_s16, r_warn;
  logic [5:0]      r_num;
  logic [4:0]      r_buf;
  logic [11:0]     r_smp_data;
  logic            r_smp_ovlp, r_smp_we;
  logic [6:0]      r_smp_idx;
  logic            r_done, r_crc_err, r_fmt_err, r_trunc_err;
  logic            r_warn_out, r_l1a_phs, r_samp16;
  logic [5:0]      r_l1a_num;
  logic [4:0]      r_l1a_buf;
  logic [15:0]     r_frm_cnt;

  logic            w_idle, w_lw_abort, w_gap_abort, w_abort;
  logic            w_take, w_dat, w_lastdat, w_fin;
  logic [6:0]      w_idx;
  logic [14:0]     w_crc_nx;
  logic            w_fmt_nx, w_crce_nx, w_phs_nx, w_s16_nx, w_warn_nx;
  logic [5:0]      w_num_nx;
  logic [4:0]      w_buf_nx;

  function automatic logic [14:0] crc_f(
    input logic [11:0] din,
    input logic [14:0] c
  );
    logic [12:0] d;
    logic [14:0] n;
    d = {1'b0, din};
    n[0] = d[0] ^ c[2];
    for (int i = 1; i <= 12; i++)
      n[i] = d[i-1] ^ d[i] ^ c[i+1] ^ c[i+2];
    n[13] = d[12] ^ c[14] ^ c[0];
    n[14] = c[1];
    return n;
  endfunction

  assign w_idle      = (r_state == S_IDLE);
  assign w_lw_abort  = DVALID & LAST_WRD & (r_state != S_TRL3);
  assign w_gap_abort = ~DVALID & ~w_idle & (r_gap == GW'(GAP_MAX));
  assign w_abort     = w_lw_abort | w_gap_abort;
  assign w_take      = DVALID & ~w_lw_abort;
  assign w_dat       = w_take & (w_idle | (r_state == S_DATA));
  assign w_idx       = w_idle ? 7'd0 : r_cnt;
  assign w_lastdat   = (w_idx == 7'(NDATA - 1));
  assign w_fin       = w_abort | (w_take & (r_state == S_TRL3));
  assign w_crc_nx    = crc_f(DIN[11:0], w_idle ? 15'd0 : r_crc);

  // State register
  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) r_state <= S_IDLE;
    else            r_state <= w_nstate;
  end

  // Next-state: advance on each taken word, abort straight to IDLE
  always_comb begin
    w_nstate = r_state;
    if (w_abort) begin
      w_nstate = S_IDLE;
    end else if (w_take) begin
      unique case (r_state)
        S_IDLE, S_DATA: w_nstate = w_lastdat ? S_CRC : S_DATA;
        S_CRC:          w_nstate = S_TRL1;
        S_TRL1:         w_nstate = S_TRL2;
        S_TRL2:         w_nstate = S_TRL3;
        S_TRL3:         w_nstate = S_IDLE;
        default:        w_nstate = S_IDLE;
      endcase
    end
  end

  // Per-word checks; a frame's flags start from zero at word 0
  always_comb begin
    w_fmt_nx  = w_idle ? 1'b0 : r_fmt;
    w_crce_nx = w_idle ? 1'b0 : r_crce;
    w_phs_nx  = w_idle ? 1'b0 : r_phs;
    w_s16_nx  = w_idle ? 1'b0 : r_s16;
    w_num_nx  = w_idle ? 6'd0 : r_num;
    w_buf_nx  = w_idle ? 5'd0 : r_buf;
    w_warn_nx = w_idle ? 1'b0 : r_warn;
    if (w_take) begin
      unique case (r_state)
        S_IDLE, S_DATA: begin
          if (DIN[15] | DIN[12]) w_fmt_nx = 1'b1;
          if (w_idx == PHS_LO) begin
            w_phs_nx = DIN[13];
          end else if (w_idx > PHS_LO && w_idx <= PHS_HI) begin
            if (DIN[13] != r_phs) w_fmt_nx = 1'b1;
          end else if (w_idx == S16_LO) begin
            w_s16_nx = DIN[13];
          end else if (w_idx > S16_LO && w_idx <= S16_HI) begin
            if (DIN[13] != r_s16) w_fmt_nx = 1'b1;
          end else if (DIN[13]) begin
            w_fmt_nx = 1'b1;
          end
        end
        S_CRC: begin
          if (DIN[15]) w_fmt_nx = 1'b1;
          w_crce_nx = (DIN[14:0] != r_crc);
        end
        S_TRL1: begin
          if (DIN != 16'h700C) w_fmt_nx = 1'b1;
        end
        S_TRL2: begin
          if (DIN[15:12] != 4'h7) w_fmt_nx = 1'b1;
          w_num_nx  = DIN[11:6];
          w_buf_nx  = DIN[5:1];
          w_warn_nx = DIN[0];
        end
        S_TRL3: begin
          if (DIN != 16'h7FFF || !LAST_WRD) w_fmt_nx = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Frame datapath: word counter, running CRC, gap timer, working flags
  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      r_cnt  <= '0;
      r_crc  <= '0;
      r_gap  <= '0;
      r_fmt  <= 1'b0;
      r_crce <= 1'b0;
      r_phs  <= 1'b0;
      r_s16  <= 1'b0;
      r_num  <= '0;
      r_buf  <= '0;
      r_warn <= 1'b0;
    end else begin
      if (w_abort)    r_cnt <= '0;
      else if (w_dat) r_cnt <= w_idx + 7'd1;
      if (w_dat) r_crc <= w_crc_nx;
      if (w_idle || DVALID || w_abort) r_gap <= '0;
      else                             r_gap <= r_gap + 1'b1;
      if (w_take) begin
        r_fmt  <= w_fmt_nx;
        r_crce <= w_crce_nx;
        r_phs  <= w_phs_nx;
        r_s16  <= w_s16_nx;
        r_num  <= w_num_nx;
        r_buf  <= w_buf_nx;
        r_warn <= w_warn_nx;
      end
    end
  end

  // Registered sample stream, one strobe per accepted data word
  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      r_smp_we   <= 1'b0;
      r_smp_data <= '0;
      r_smp_ovlp <= 1'b0;
      r_smp_idx  <= '0;
    end else begin
      r_smp_we <= w_dat;
      if (w_dat) begin
        r_smp_data <= DIN[11:0];
        r_smp_ovlp <= ~DIN[14];
        r_smp_idx  <= w_idx;
      end
    end
  end

  // Status outputs load together with the FRM_DONE pulse, then hold
  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      r_done      <= 1'b0;
      r_crc_err   <= 1'b0;
      r_fmt_err   <= 1'b0;
      r_trunc_err <= 1'b0;
      r_l1a_num   <= '0;
      r_l1a_buf   <= '0;
      r_warn_out  <= 1'b0;
      r_l1a_phs   <= 1'b0;
      r_samp16    <= 1'b0;
      r_frm_cnt   <= '0;
    end else begin
      r_done <= w_fin;
      if (w_fin) begin
        r_crc_err   <= w_crce_nx;
        r_fmt_err   <= w_fmt_nx;
        r_trunc_err <= w_abort;
        r_l1a_num   <= w_num_nx;
        r_l1a_buf   <= w_buf_nx;
        r_warn_out  <= w_warn_nx;
        r_l1a_phs   <= w_phs_nx;
        r_samp16    <= w_s16_nx;
        r_frm_cnt   <= r_frm_cnt + 16'd1;
      end
    end
  end

`ifdef CHANLINK_RX_ERRCNT_EN
  logic [15:0] r_err_cnt;

  // Saturating count of completed frames carrying any error
  always_ff @(posedge WCLK or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      r_err_cnt <= '0;
    end else if (w_fin && (w_fmt_nx || w_crce_nx || w_abort)
                 && r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign ERR_CNT = r_err_cnt;
`endif

  assign SMP_DATA  = r_smp_data;
  assign SMP_OVLP  = r_smp_ovlp;
  assign SMP_IDX   = r_smp_idx;
  assign SMP_WE    = r_smp_we;
  assign FRM_DONE  = r_done;
  assign CRC_ERR   = r_crc_err;
  assign FMT_ERR   = r_fmt_err;
  assign TRUNC_ERR = r_trunc_err;
  assign L1A_NUM   = r_l1a_num;
  assign L1A_BUF   = r_l1a_buf;
  assign WARN_OUT  = r_warn_out;
  assign L1A_PHS   = r_l1a_phs;
  assign SAMP16    = r_samp16;
  assign FRM_CNT   = r_frm_cnt;

endmodule

// File: tb/tb_chanlink_frame_rx.sv
// tb_chanlink_frame_rx: directed + randomized frames against a
// behavioural frame/CRC model.
module tb_chanlink_frame_rx;

  logic        WCLK = 1'b0;
  logic        RST_RESYNC;
  logic [15:0] DIN;
  logic        DVALID, LAST_WRD;
  logic [11:0] SMP_DATA;
  logic        SMP_OVLP, SMP_WE, FRM_DONE;
  logic [6:0]  SMP_IDX;
  logic        CRC_ERR, FMT_ERR, TRUNC_ERR, WARN_OUT, L1A_PHS, SAMP16;
  logic [5:0]  L1A_NUM;
  logic [4:0]  L1A_BUF;
  logic [15:0] FRM_CNT;
`ifdef CHANLINK_RX_ERRCNT_EN
  logic [15:0] ERR_CNT;
`endif

  always #5 WCLK = ~WCLK;

  chanlink_frame_rx dut (
    .WCLK(WCLK), .RST_RESYNC(RST_RESYNC), .DIN(DIN),
    .DVALID(DVALID), .LAST_WRD(LAST_WRD),
    .SMP_DATA(SMP_DATA), .SMP_OVLP(SMP_OVLP), .SMP_IDX(SMP_IDX),
    .SMP_WE(SMP_WE), .FRM_DONE(FRM_DONE), .CRC_ERR(CRC_ERR),
    .FMT_ERR(FMT_ERR), .TRUNC_ERR(TRUNC_ERR), .L1A_NUM(L1A_NUM),
    .L1A_BUF(L1A_BUF), .WARN_OUT(WARN_OUT), .L1A_PHS(L1A_PHS),
    .SAMP16(SAMP16), .FRM_CNT(FRM_CNT)
`ifdef CHANLINK_RX_ERRCNT_EN
    , .ERR_CNT(ERR_CNT)
`endif
  );

  int ntests = 0;
  int nfail  = 0;
  int done_cnt = 0;
  int exp_frm = 0;

  logic [19:0] smp_q[$];
  logic [19:0] exp_q[$];

  logic [11:0] smp_a [96];
  logic        ovl_a [96];
  logic [15:0] fw [100];
  logic        m_phs, m_s16, m_warn;
  logic [5:0]  m_num;
  logic [4:0]  m_buf;

  always @(negedge WCLK) begin
    if (SMP_WE) smp_q.push_back({SMP_IDX, SMP_OVLP, SMP_DATA});
    if (FRM_DONE) done_cnt++;
  end

  function automatic logic [14:0] crc_step(
    input logic [14:0] c, input logic [11:0] s);
    logic [14:0] d, n;
    d = {3'b0, s};
    n = (d ^ (d << 1)) ^ ((c >> 1) ^ (c >> 2));
    n[0]  = d[0] ^ c[2];
    n[13] = d[12] ^ c[14] ^ c[0];
    n[14] = c[1];
    return n;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build(input bit ramp, input logic p, input logic s,
                       input logic [5:0] n, input logic [4:0] b,
                       input logic w);
    logic [14:0] crc;
    logic ser;
    crc = '0;
    for (int i = 0; i < 96; i++) begin
      smp_a[i] = ramp ? 12'(i) : 12'($urandom);
      ovl_a[i] = ramp ? 1'b0 : 1'($urandom);
      crc = crc_step(crc, smp_a[i]);
      ser = (i >= 72 && i <= 77) ? p : (i >= 90 && i <= 95) ? s : 1'b0;
      fw[i] = {1'b0, ~ovl_a[i], ser, 1'b0, smp_a[i]};
    end
    fw[96] = {1'b0, crc};
    fw[97] = 16'h700C;
    fw[98] = {4'h7, n, b, w};
    fw[99] = 16'h7FFF;
    m_phs = p; m_s16 = s; m_num = n; m_buf = b; m_warn = w;
  endtask

  task automatic build_rand();
    build(1'b0, 1'($urandom), 1'($urandom), 6'($urandom),
          5'($urandom), 1'($urandom));
  endtask

  task automatic idle_cycle();
    @(posedge WCLK); #1;
    DVALID = 1'b0; LAST_WRD = 1'b0; DIN = 16'($urandom);
  endtask

  task automatic send_frame(input int nw, input int lw_at,
                            input bit rgap, input int big_at,
                            input bit tail);
    int g;
    for (int i = 0; i < nw; i++) begin
      g = (i == big_at) ? 15 :
          (rgap && i > 0) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) idle_cycle();
      @(posedge WCLK); #1;
      DIN = fw[i]; DVALID = 1'b1; LAST_WRD = (i == lw_at);
      if (i < 96 && i != lw_at)
        exp_q.push_back({7'(i), ovl_a[i], smp_a[i]});
    end
    if (tail) idle_cycle();
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int k = 0; k < 300 && done_cnt < target; k++) begin
      @(posedge WCLK); #3;
    end
    chk(tag, done_cnt, target);
  endtask

  task automatic chk_samples(input string tag);
    int bad;
    int n;
    chk({tag, "_nsmp"}, smp_q.size(), exp_q.size());
    bad = 0;
    n = (smp_q.size() < exp_q.size()) ? smp_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (smp_q[i] !== exp_q[i]) bad++;
    chk({tag, "_smpbad"}, bad, 0);
    smp_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_status(input string tag, input logic ce,
                            input logic fe, input logic te,
                            input logic [5:0] n, input logic [4:0] b,
                            input logic w, input logic p,
                            input logic s);
    chk({tag, "_crc"},   32'(CRC_ERR),   32'(ce));
    chk({tag, "_fmt"},   32'(FMT_ERR),   32'(fe));
    chk({tag, "_trunc"}, 32'(TRUNC_ERR), 32'(te));
    chk({tag, "_num"},   32'(L1A_NUM),   32'(n));
    chk({tag, "_buf"},   32'(L1A_BUF),   32'(b));
    chk({tag, "_warn"},  32'(WARN_OUT),  32'(w));
    chk({tag, "_phs"},   32'(L1A_PHS),   32'(p));
    chk({tag, "_s16"},   32'(SAMP16),    32'(s));
    chk({tag, "_frmcnt"}, 32'(FRM_CNT),  32'(exp_frm));
  endtask

  task automatic chk_good(input string tag);
    chk_status(tag, 1'b0, 1'b0, 1'b0, m_num, m_buf, m_warn,
               m_phs, m_s16);
  endtask

  initial begin
    RST_RESYNC = 1'b1; DIN = '0; DVALID = 1'b0; LAST_WRD = 1'b0;
    repeat (3) @(posedge WCLK);
    #3 RST_RESYNC = 1'b0;
    @(posedge WCLK); #3;
    chk("rst_we", 32'(SMP_WE), 0);
    chk("rst_done", 32'(FRM_DONE), 0);
    chk_status("rst", 0, 0, 0, 0, 0, 0, 0, 0);

    // clean ramp frame, with a 15-cycle gap that must not time out
    build(1'b1, 1'b1, 1'b1, 6'h2A, 5'd3, 1'b0);
    send_frame(100, 99, 1'b0, 20, 1'b1);
    exp_frm++;
    wait_done("t1_done", exp_frm);
    chk_samples("t1");
    chk_good("t1");

    // CRC word bit 0 flipped
    build(1'b1, 1'b1, 1'b1, 6'h2A, 5'd3, 1'b0);
    fw[96][0] = ~fw[96][0];
    send_frame(100, 99, 1'b1, -1, 1'b1);
    exp_frm++;
    wait_done("t2_done", exp_frm);
    chk_samples("t2");
    chk_status("t2", 1'b1, 1'b0, 1'b0, 6'h2A, 5'd3, 1'b0, 1'b1, 1'b1);

    // serial bit disagreement on word 74
    build(1'b1, 1'b1, 1'b1, 6'h2A, 5'd3, 1'b0);
    fw[74][13] = 1'b0;
    send_frame(100, 99, 1'b1, -1, 1'b1);
    exp_frm++;
    wait_done("t3_done", exp_frm);
    chk_samples("t3");
    chk_status("t3", 1'b0, 1'b1, 1'b0, 6'h2A, 5'd3, 1'b0, 1'b1, 1'b1);

    // 16-cycle gap after word 40
    build_rand();
    send_frame(41, -1, 1'b1, -1, 1'b1);
    exp_frm++;
    wait_done("t4_done", exp_frm);
    chk_samples("t4");
    chk_status("t4", 1'b0, 1'b0, 1'b1, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    build_rand();
    send_frame(100, 99, 1'b1, -1, 1'b1);
    exp_frm++;
    wait_done("t4b_done", exp_frm);
    chk_samples("t4b");
    chk_good("t4b");

    // LAST_WRD on word 97
    build_rand();
    send_frame(98, 97, 1'b1, -1, 1'b1);
    exp_frm++;
    wait_done("t5_done", exp_frm);
    chk_samples("t5");
    chk_status("t5", 1'b0, 1'b0, 1'b1, 6'd0, 5'd0, 1'b0, m_phs, m_s16);
`ifdef CHANLINK_RX_ERRCNT_EN
    chk("t5_errcnt", 32'(ERR_CNT), 4);
`endif

    // back-to-back random frames: FRM_DONE overlaps next word 0
    for (int f = 0; f < 4; f++) begin
      build_rand();
      send_frame(100, 99, 1'b1, -1, f == 3);
    end
    exp_frm += 4;
    wait_done("rnd_done", exp_frm);
    chk_samples("rnd");
    chk_good("rnd");

    // TRL3 word without LAST_WRD
    build_rand();
    send_frame(100, -1, 1'b1, -1, 1'b1);
    exp_frm++;
    wait_done("t7_done", exp_frm);
    chk_samples("t7");
    chk_status("t7", 1'b0, 1'b1, 1'b0, m_num, m_buf, m_warn,
               m_phs, m_s16);
`ifdef CHANLINK_RX_ERRCNT_EN
    chk("t7_errcnt", 32'(ERR_CNT), 5);
`endif

    // reset in the middle of a frame
    build_rand();
    send_frame(50, -1, 1'b0, -1, 1'b0);
    @(posedge WCLK); #3;
    DVALID = 1'b0;
    RST_RESYNC = 1'b1;
    #1;
    exp_frm = 0;
    chk_status("t6", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_we", 32'(SMP_WE), 0);
    #3 RST_RESYNC = 1'b0;
    begin
      int d0;
      d0 = done_cnt;
      repeat (20) idle_cycle();
      chk("t6_nodone", done_cnt, d0);
    end
    chk("t6_frmcnt", 32'(FRM_CNT), 0);
`ifdef CHANLINK_RX_ERRCNT_EN
    chk("t6_errcnt", 32'(ERR_CNT), 0);
`endif
    smp_q.delete();
    exp_q.delete();

    // recovery after reset
    build_rand();
    send_frame(100, 99, 1'b1, -1, 1'b1);
    exp_frm++;
    wait_done("t8_done", done_cnt + 1);
    chk_samples("t8");
    chk_good("t8");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
